// File: rtl/iic_pkg.sv
// Shared definitions for the IIC_CORE request arbiter.
package iic_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_BUSY    = 2'd2,
      ST_WR_HOLD = 2'd3
   } arb_state_t;

   // EEPROM device constants
   localparam logic [6:0]  EEPROM_DEV_ADDR = 7'b1010000;
   localparam int unsigned EEPROM_ADDR_W   = 13;

   // Default timing constants in clk cycles
   localparam int unsigned WR_WAIT_DEF     = 200000;
   localparam int unsigned TIMEOUT_CYC_DEF = 1000000;

endpackage

// File: rtl/iic_done_sync.sv
// Two-flop synchroniser for IIC_CORE done plus rising-edge detector.
// Stages reset to 1 so a done level left over from an aborted transaction
// cannot appear as a fresh edge after reset.
module iic_done_sync
   import iic_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic core_done,
   output logic done_s_rise
);

   logic r_meta;
   logic r_done_s;
   logic r_done_d;

   // Synchronise core_done and keep one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta   <= 1'b1;
         r_done_s <= 1'b1;
         r_done_d <= 1'b1;
      end else begin
         r_meta   <= core_done;
         r_done_s <= r_meta;
         r_done_d <= r_done_s;
      end
   end

   assign done_s_rise = r_done_s & ~r_done_d;

endmodule

// File: rtl/iic_req_arbiter.sv
// Round-robin scheduler of two requesters onto the shared IIC_CORE EEPROM engine.
// Optional feature macro: IIC_ARB_TIMEOUT_EN (done watchdog in BUSY, drives err_o).
module iic_req_arbiter
   import iic_pkg::*;
#(
   parameter int unsigned ADDR_W      = EEPROM_ADDR_W,
   parameter int unsigned WR_WAIT     = WR_WAIT_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_i,
   input  logic [1:0]        we_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [7:0]        wdata0_i,
   input  logic [7:0]        wdata1_i,
   output logic [1:0]        gnt_o,
   output logic [1:0]        done_o,
   output logic [7:0]        rdata_o,
   output logic              err_o,
   output logic              core_wr_en,
   output logic              core_re_en,
   output logic [ADDR_W-1:0] core_addr,
   output logic [7:0]        core_wdata,
   input  logic [7:0]        core_rdata,
   input  logic              core_done
);

   localparam int unsigned     HOLD_W    = $clog2(WR_WAIT + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WR_WAIT - 1);

   arb_state_t        r_state,  w_state_nxt;
   logic              r_win,    w_win_nxt;
   logic              r_we,     w_we_nxt;
   logic              r_last,   w_last_nxt;
   logic [HOLD_W-1:0] r_hold,   w_hold_nxt;
   logic [1:0]        r_gnt,    w_gnt_nxt;
   logic [1:0]        r_done,   w_done_nxt;
   logic [7:0]        r_rdata,  w_rdata_nxt;
   logic              r_wr_en,  w_wr_en_nxt;
   logic              r_re_en,  w_re_en_nxt;
   logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
   logic [7:0]        r_wdata,  w_wdata_nxt;
   logic              w_done_rise;
   logic              w_pick;

`ifdef IIC_ARB_TIMEOUT_EN
   localparam int unsigned   TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
   logic            r_err,    w_err_nxt;
`else
   logic            w_unused_to;
   assign w_unused_to = |32'(TIMEOUT_CYC);
`endif

   iic_done_sync u_done_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_done   (core_done),
      .done_s_rise (w_done_rise)
   );

   // Winner: the sole requester, or the one not granted last under contention
   assign w_pick = (req_i == 2'b11) ? ~r_last : req_i[1];

   // State and registered-output update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_win   <= 1'b0;
         r_we    <= 1'b0;
         r_last  <= 1'b1;
         r_hold  <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_rdata <= '0;
         r_wr_en <= 1'b0;
         r_re_en <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
`ifdef IIC_ARB_TIMEOUT_EN
         r_to_cnt <= '0;
         r_err    <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_win   <= w_win_nxt;
         r_we    <= w_we_nxt;
         r_last  <= w_last_nxt;
         r_hold  <= w_hold_nxt;
         r_gnt   <= w_gnt_nxt;
         r_done  <= w_done_nxt;
         r_rdata <= w_rdata_nxt;
         r_wr_en <= w_wr_en_nxt;
         r_re_en <= w_re_en_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
`ifdef IIC_ARB_TIMEOUT_EN
         r_to_cnt <= w_to_cnt_nxt;
         r_err    <= w_err_nxt;
`endif
      end
   end

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt = r_state;
      w_win_nxt   = r_win;
      w_we_nxt    = r_we;
      w_last_nxt  = r_last;
      w_hold_nxt  = r_hold;
      w_gnt_nxt   = r_gnt;
      w_done_nxt  = '0;
      w_rdata_nxt = r_rdata;
      w_wr_en_nxt = 1'b0;
      w_re_en_nxt = 1'b0;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
`ifdef IIC_ARB_TIMEOUT_EN
      w_to_cnt_nxt = r_to_cnt;
      w_err_nxt    = 1'b0;
`endif

      case (r_state)
         ST_IDLE: begin
            if (|req_i) begin
               w_win_nxt   = w_pick;
               w_we_nxt    = we_i[w_pick];
               w_addr_nxt  = w_pick ? addr1_i  : addr0_i;
               w_wdata_nxt = w_pick ? wdata1_i : wdata0_i;
               w_gnt_nxt   = w_pick ? 2'b10 : 2'b01;
               w_state_nxt = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            w_wr_en_nxt = r_we;
            w_re_en_nxt = ~r_we;
`ifdef IIC_ARB_TIMEOUT_EN
            w_to_cnt_nxt = '0;
`endif
            w_state_nxt = ST_BUSY;
         end

         ST_BUSY: begin
            if (w_done_rise) begin
               if (!r_we) begin
                  w_rdata_nxt = core_rdata;
               end
               w_done_nxt[r_win] = 1'b1;
               w_gnt_nxt   = '0;
               w_last_nxt  = r_win;
               w_addr_nxt  = '0;
               w_wdata_nxt = '0;
               w_hold_nxt  = '0;
               w_state_nxt = r_we ? ST_WR_HOLD : ST_IDLE;
            end
`ifdef IIC_ARB_TIMEOUT_EN
            else if (r_to_cnt == TO_LAST) begin
               w_done_nxt[r_win] = 1'b1;
               w_err_nxt   = 1'b1;
               w_gnt_nxt   = '0;
               w_last_nxt  = r_win;
               w_addr_nxt  = '0;
               w_wdata_nxt = '0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            end
`endif
         end

         ST_WR_HOLD: begin
            if (r_hold == HOLD_LAST) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_hold_nxt = r_hold + HOLD_W'(1);
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign gnt_o      = r_gnt;
   assign done_o     = r_done;
   assign rdata_o    = r_rdata;
   assign core_wr_en = r_wr_en;
   assign core_re_en = r_re_en;
   assign core_addr  = r_addr;
   assign core_wdata = r_wdata;
`ifdef IIC_ARB_TIMEOUT_EN
   assign err_o      = r_err;
`else
   assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_iic_req_arbiter.sv
// Self-checking bench for iic_req_arbiter with a behavioural IIC_CORE model.
module tb_iic_req_arbiter;

   localparam int unsigned ADDR_W      = 13;
   localparam int unsigned WR_WAIT     = 100;
   localparam int unsigned TIMEOUT_CYC = 64;

   typedef struct packed {
      logic [1:0] done;
      logic       err;
      logic [7:0] rdata;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        req_i;
   logic [1:0]        we_i;
   logic [ADDR_W-1:0] addr0_i;
   logic [ADDR_W-1:0] addr1_i;
   logic [7:0]        wdata0_i;
   logic [7:0]        wdata1_i;
   logic [1:0]        gnt_o;
   logic [1:0]        done_o;
   logic [7:0]        rdata_o;
   logic              err_o;
   logic              core_wr_en;
   logic              core_re_en;
   logic [ADDR_W-1:0] core_addr;
   logic [7:0]        core_wdata;
   logic [7:0]        core_rdata = 8'h00;
   logic              core_done;

   logic model_done = 1'b0;
   logic stale_done = 1'b0;
   assign core_done = model_done | stale_done;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t sb_q[$];
   int   exp_last  = 1;
   logic [7:0] exp_rdata = 8'h00;

   // core model controls and state
   int         core_lat  = 10;
   logic       core_mute = 1'b0;
   logic [7:0] rd_val    = 8'h00;
   int         strobe_cnt = 0;
   logic       pend = 1'b0;
   int         lat_cnt = 0;
   int         hi_cnt = 0;

   // monitor state
   int   core_rise_cyc = 0;
   logic prev_core_done = 1'b0;
   logic [1:0] prev_gnt = 2'b00;
   int   gnt_rise_cnt = 0;
   int   done_cnt = 0;

   iic_req_arbiter #(
      .ADDR_W      (ADDR_W),
      .WR_WAIT     (WR_WAIT),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr0_i    (addr0_i),
      .addr1_i    (addr1_i),
      .wdata0_i   (wdata0_i),
      .wdata1_i   (wdata1_i),
      .gnt_o      (gnt_o),
      .done_o     (done_o),
      .rdata_o    (rdata_o),
      .err_o      (err_o),
      .core_wr_en (core_wr_en),
      .core_re_en (core_re_en),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_done  (core_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // IIC_CORE model: a strobe drops done, then done rises core_lat cycles later for 4 cycles
   always @(posedge clk) begin
      if (core_wr_en || core_re_en) begin
         strobe_cnt <= strobe_cnt + 1;
         model_done <= 1'b0;
         pend       <= !core_mute;
         lat_cnt    <= core_lat;
      end else if (pend) begin
         if (lat_cnt <= 1) begin
            model_done <= 1'b1;
            core_rdata <= rd_val;
            pend       <= 1'b0;
            hi_cnt     <= 4;
         end else begin
            lat_cnt <= lat_cnt - 1;
         end
      end else if (hi_cnt != 0) begin
         hi_cnt <= hi_cnt - 1;
         if (hi_cnt == 1) model_done <= 1'b0;
      end
   end

   // Event monitor
   always @(negedge clk) begin
      if (core_done && !prev_core_done) core_rise_cyc = cyc;
      prev_core_done = core_done;
      if (gnt_o != 2'b00 && prev_gnt == 2'b00) gnt_rise_cnt++;
      prev_gnt = gnt_o;
      if (done_o != 2'b00) done_cnt++;
   end

   // Reference round-robin pick; returns the expected one-hot grant
   function automatic logic [1:0] model_pick(input logic [1:0] r);
      int w;
      if (r == 2'b11) w = (exp_last == 1) ? 0 : 1;
      else            w = r[1] ? 1 : 0;
      exp_last = w;
      return (w == 1) ? 2'b10 : 2'b01;
   endfunction

   function automatic exp_t mk_exp(input logic [1:0] d, input logic e, input logic [7:0] rd);
      exp_t x;
      x.done  = d;
      x.err   = e;
      x.rdata = rd;
      return x;
   endfunction

   // Bounded wait for a done_o pulse; an expired bound counts as a failure
   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done_o != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL wait_done: no done_o within %0d cycles (got 0, required pulse)", limit);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++; if (gnt_o !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b required 00", gnt_o); end
      n_checks++; if (done_o !== 2'b00 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b/%b required 00/0", done_o, err_o); end
      n_checks++; if (rdata_o !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h required 00", rdata_o); end
      n_checks++; if ({core_wr_en, core_re_en} !== 2'b00 || core_addr !== '0 || core_wdata !== 8'h00) begin
         n_fail++; $display("FAIL reset_core: got en=%b addr=%0d wdata=%h required 0", {core_wr_en, core_re_en}, core_addr, core_wdata);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_read;
      exp_t e; bit ok; int sc0;
      @(negedge clk);
      core_lat = 50; rd_val = 8'hA5; sc0 = strobe_cnt;
      sb_q.push_back(mk_exp(model_pick(2'b01), 1'b0, 8'hA5));
      exp_rdata = 8'hA5;
      req_i = 2'b01; we_i = 2'b00; addr0_i = 13'd30;
      @(negedge clk);
      n_checks++; if (gnt_o !== 2'b01 || core_re_en !== 1'b0) begin n_fail++; $display("FAIL read_gnt: got gnt=%b re=%b required 01/0", gnt_o, core_re_en); end
      @(negedge clk);
      n_checks++; if (core_re_en !== 1'b1 || core_wr_en !== 1'b0) begin n_fail++; $display("FAIL read_strobe: got re=%b wr=%b required 1/0", core_re_en, core_wr_en); end
      n_checks++; if (core_addr !== 13'd30) begin n_fail++; $display("FAIL read_addr: got %0d required 30", core_addr); end
      @(negedge clk);
      n_checks++; if (core_re_en !== 1'b0) begin n_fail++; $display("FAIL read_strobe_width: got re=%b required 0", core_re_en); end
      wait_done(200, ok);
      if (ok) begin
         req_i = 2'b00;
         e = sb_q.pop_front();
         n_checks++; if ({done_o, err_o, rdata_o} !== {e.done, e.err, e.rdata}) begin
            n_fail++; $display("FAIL read_done: got %b/%b/%h required %b/%b/%h", done_o, err_o, rdata_o, e.done, e.err, e.rdata);
         end
         n_checks++; if (cyc - core_rise_cyc != 3) begin n_fail++; $display("FAIL read_latency: got %0d required 3", cyc - core_rise_cyc); end
         n_checks++; if (strobe_cnt - sc0 != 1) begin n_fail++; $display("FAIL read_strobe_count: got %0d required 1", strobe_cnt - sc0); end
      end
      repeat (5) @(negedge clk);
      n_checks++; if (rdata_o !== 8'hA5 || gnt_o !== 2'b00) begin n_fail++; $display("FAIL read_hold: got rdata=%h gnt=%b required a5/00", rdata_o, gnt_o); end
   endtask

   task automatic test_write_hold;
      exp_t e; bit ok; int t0; bit seen;
      @(negedge clk);
      core_lat = 12;
      sb_q.push_back(mk_exp(model_pick(2'b01), 1'b0, exp_rdata));
      req_i = 2'b01; we_i = 2'b01; addr0_i = 13'd40; wdata0_i = 8'h80;
      @(negedge clk);
      n_checks++; if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL wr_gnt: got %b required 01", gnt_o); end
      @(negedge clk);
      n_checks++; if (core_wr_en !== 1'b1 || core_re_en !== 1'b0 || core_addr !== 13'd40 || core_wdata !== 8'h80) begin
         n_fail++; $display("FAIL wr_strobe: got wr=%b re=%b addr=%0d data=%h required 1/0/40/80", core_wr_en, core_re_en, core_addr, core_wdata);
      end
      wait_done(100, ok);
      if (!ok) return;
      t0 = cyc;
      req_i = 2'b10; we_i = 2'b00; addr1_i = 13'd55;
      core_lat = 8; rd_val = 8'h3C;
      e = sb_q.pop_front();
      n_checks++; if ({done_o, err_o, rdata_o} !== {e.done, e.err, e.rdata}) begin
         n_fail++; $display("FAIL wr_done: got %b/%b/%h required %b/%b/%h", done_o, err_o, rdata_o, e.done, e.err, e.rdata);
      end
      n_checks++; if (core_addr !== '0 || core_wdata !== 8'h00) begin n_fail++; $display("FAIL wr_hold_bus: got addr=%0d data=%h required 0/00", core_addr, core_wdata); end
      sb_q.push_back(mk_exp(model_pick(2'b10), 1'b0, 8'h3C));
      exp_rdata = 8'h3C;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (gnt_o != 2'b00) begin seen = 1'b1; break; end
      end
      n_checks++; if (!seen || gnt_o !== 2'b10 || cyc - t0 != int'(WR_WAIT) + 1) begin
         n_fail++; $display("FAIL wr_turnaround: got gnt=%b after %0d cycles required 10 after %0d", gnt_o, cyc - t0, WR_WAIT + 1);
      end
      wait_done(100, ok);
      if (ok) begin
         req_i = 2'b00;
         e = sb_q.pop_front();
         n_checks++; if ({done_o, err_o, rdata_o} !== {e.done, e.err, e.rdata}) begin
            n_fail++; $display("FAIL wr_next_read: got %b/%b/%h required %b/%b/%h", done_o, err_o, rdata_o, e.done, e.err, e.rdata);
         end
      end
   endtask

   task automatic test_contention;
      exp_t e; bit ok;
      @(negedge clk);
      core_lat = 5; rd_val = 8'h77;
      for (int k = 0; k < 4; k++) sb_q.push_back(mk_exp(model_pick(2'b11), 1'b0, 8'h77));
      exp_rdata = 8'h77;
      req_i = 2'b11; we_i = 2'b00; addr0_i = 13'd1; addr1_i = 13'd2;
      for (int k = 0; k < 4; k++) begin
         wait_done(100, ok);
         if (!ok) break;
         if (k == 3) req_i = 2'b00;
         e = sb_q.pop_front();
         n_checks++; if ({done_o, err_o, rdata_o} !== {e.done, e.err, e.rdata}) begin
            n_fail++; $display("FAIL contention_%0d: got %b/%b/%h required %b/%b/%h", k, done_o, err_o, rdata_o, e.done, e.err, e.rdata);
         end
      end
      req_i = 2'b00;
      sb_q.delete();
   endtask

   task automatic test_req_drop;
      exp_t e; bit ok; int g0;
      @(negedge clk);
      core_lat = 20; rd_val = 8'h5A;
      sb_q.push_back(mk_exp(model_pick(2'b01), 1'b0, 8'h5A));
      exp_rdata = 8'h5A;
      req_i = 2'b01; we_i = 2'b00; addr0_i = 13'd7;
      repeat (2) @(negedge clk);
      n_checks++; if (core_re_en !== 1'b1) begin n_fail++; $display("FAIL drop_strobe: got %b required 1", core_re_en); end
      @(negedge clk);
      req_i = 2'b00;
      g0 = gnt_rise_cnt;
      wait_done(100, ok);
      if (ok) begin
         e = sb_q.pop_front();
         n_checks++; if ({done_o, err_o, rdata_o} !== {e.done, e.err, e.rdata}) begin
            n_fail++; $display("FAIL drop_done: got %b/%b/%h required %b/%b/%h", done_o, err_o, rdata_o, e.done, e.err, e.rdata);
         end
      end
      repeat (20) @(negedge clk);
      n_checks++; if (gnt_rise_cnt != g0 || gnt_o !== 2'b00) begin n_fail++; $display("FAIL drop_spurious_gnt: got %0d grants required 0", gnt_rise_cnt - g0); end
   endtask

   task automatic test_idle_done;
      int d0;
      @(negedge clk);
      d0 = done_cnt;
      stale_done = 1'b1;
      repeat (5) @(negedge clk);
      stale_done = 1'b0;
      repeat (10) @(negedge clk);
      n_checks++; if (done_cnt != d0 || gnt_o !== 2'b00) begin n_fail++; $display("FAIL idle_done_ignored: got %0d done pulses required 0", done_cnt - d0); end
   endtask

   task automatic test_reset_mid_busy;
      exp_t e; bit ok;
      @(negedge clk);
      core_mute = 1'b1;
      req_i = 2'b01; we_i = 2'b00; addr0_i = 13'd9;
      repeat (2) @(negedge clk);
      req_i = 2'b00;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      stale_done = 1'b1;
      #1;
      n_checks++; if (gnt_o !== 2'b00 || done_o !== 2'b00 || err_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy_gnt: got gnt=%b done=%b err=%b required 0", gnt_o, done_o, err_o); end
      n_checks++; if (rdata_o !== 8'h00) begin n_fail++; $display("FAIL rst_busy_rdata: got %h required 00", rdata_o); end
      n_checks++; if (core_re_en !== 1'b0 || core_wr_en !== 1'b0 || core_addr !== '0) begin
         n_fail++; $display("FAIL rst_busy_core: got re=%b wr=%b addr=%0d required 0", core_re_en, core_wr_en, core_addr);
      end
      exp_last = 1;
      exp_rdata = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      core_mute = 1'b0; core_lat = 10; rd_val = 8'hC3;
      sb_q.push_back(mk_exp(model_pick(2'b10), 1'b0, 8'hC3));
      exp_rdata = 8'hC3;
      req_i = 2'b10; we_i = 2'b00; addr1_i = 13'd77;
      repeat (6) @(negedge clk);
      stale_done = 1'b0;
      wait_done(100, ok);
      if (ok) begin
         req_i = 2'b00;
         e = sb_q.pop_front();
         n_checks++; if ({done_o, err_o, rdata_o} !== {e.done, e.err, e.rdata}) begin
            n_fail++; $display("FAIL rst_after_done: got %b/%b/%h required %b/%b/%h", done_o, err_o, rdata_o, e.done, e.err, e.rdata);
         end
         n_checks++; if (cyc - core_rise_cyc != 3) begin n_fail++; $display("FAIL rst_stale_ignored: got %0d cycles required 3", cyc - core_rise_cyc); end
      end
      req_i = 2'b00;
   endtask

`ifdef IIC_ARB_TIMEOUT_EN
   task automatic test_timeout;
      exp_t e; bit ok; int tb_busy;
      @(negedge clk);
      core_mute = 1'b1;
      sb_q.push_back(mk_exp(model_pick(2'b01), 1'b1, exp_rdata));
      req_i = 2'b01; we_i = 2'b00; addr0_i = 13'd3;
      repeat (2) @(negedge clk);
      tb_busy = cyc;
      n_checks++; if (core_re_en !== 1'b1) begin n_fail++; $display("FAIL to_strobe: got %b required 1", core_re_en); end
      wait_done(200, ok);
      if (ok) begin
         req_i = 2'b00;
         e = sb_q.pop_front();
         n_checks++; if ({done_o, err_o, rdata_o} !== {e.done, e.err, e.rdata}) begin
            n_fail++; $display("FAIL to_done: got %b/%b/%h required %b/%b/%h", done_o, err_o, rdata_o, e.done, e.err, e.rdata);
         end
         n_checks++; if (cyc - tb_busy != int'(TIMEOUT_CYC)) begin n_fail++; $display("FAIL to_latency: got %0d required %0d", cyc - tb_busy, TIMEOUT_CYC); end
      end
      req_i = 2'b00;
      core_mute = 1'b0;
      repeat (3) @(negedge clk);
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req_i = 2'b00; we_i = 2'b00;
      addr0_i = '0; addr1_i = '0;
      wdata0_i = 8'h00; wdata1_i = 8'h00;
      test_reset();
      test_read();
      test_write_hold();
      test_contention();
      test_req_drop();
      test_idle_done();
      test_reset_mid_busy();
`ifdef IIC_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iic_req_arbiter.md
# iic_req_arbiter

Two-requester scheduler for the shared IIC_CORE EEPROM engine (slave 7'b1010000, 13-bit byte address, single-byte transfers). It grants the core round-robin to one requester at a time, issues a single-cycle wr_en/re_en strobe, and waits for the core's done. After every write it holds the core for the EEPROM internal write cycle. It sits between the plate-store controller (requester 0) and a secondary client such as config/log (requester 1) on one side, and IIC_CORE on the other.

## Interface
- ADDR_W, 13, EEPROM byte-address width
- WR_WAIT, 200000, post-write hold in clk cycles (≥1)
- TIMEOUT_CYC, 1000000, done watchdog limit in clk cycles (used only with IIC_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_i  in  2  per-requester transaction request (level)
- we_i  in  2  per-requester direction: 1 = write, 0 = read
- addr0_i / addr1_i  in  ADDR_W  byte address, requester 0/1
- wdata0_i / wdata1_i  in  8  write byte, requester 0/1
- gnt_o  out  2  one-hot grant, held from acceptance until done_o
- done_o  out  2  one-cycle completion pulse to the granted requester
- rdata_o  out  8  read byte, valid from done_o onward until the next read completes
- err_o  out  1  one-cycle pulse with done_o when the transaction was aborted
- core_wr_en / core_re_en  out  1  one-cycle start strobes to IIC_CORE
- core_addr  out  ADDR_W  address to IIC_CORE
- core_wdata  out  8  write byte to IIC_CORE
- core_rdata  in  8  read byte from IIC_CORE
- core_done  in  1  IIC_CORE completion

## Operation
- States: IDLE, ISSUE, BUSY, WR_HOLD.
- IDLE: if any req_i is set, pick a winner. With a single request, that requester wins. With both set, the requester not granted last wins; last_gnt resets to 1, so requester 0 wins first. Latch the winner's we, addr, and wdata into internal registers. Set gnt_o and go to ISSUE.
- ISSUE: assert core_wr_en (we=1) or core_re_en (we=0) for exactly one cycle, then go to BUSY.
- BUSY: wait for a rising edge of done_s, the 2-FF-synchronised core_done. On the edge:
  - Capture core_rdata into rdata_o (reads only).
  - Pulse done_o[winner] and drop gnt_o.
  - Update last_gnt.
  - Write: go to WR_HOLD. Read: go to IDLE.
- WR_HOLD: count WR_WAIT cycles, then go to IDLE. New requests are not granted during this state.
- core_addr and core_wdata come from the latched registers from ISSUE through BUSY. In IDLE and WR_HOLD they are 0. Requester inputs are never passed combinationally to the core.
- If a requester drops req_i after grant, the transaction still completes and done_o still pulses.
- If req_i stays high after done_o, it is treated as a new request. Under contention, round-robin still alternates.
- A done edge seen in IDLE or WR_HOLD is ignored.
- Reset value of every output is 0. Reset mid-transaction returns the block to IDLE at once, without waiting for core_done, and the core enables go low.

## Timing
- Request accepted in IDLE: gnt_o is high the next cycle, and the core strobe follows one cycle later.
- done_o fires 3 cycles after core_done rises: 2 sync stages plus the edge register.
- Read turnaround: the earliest next grant is the cycle after done_o.
- Write turnaround: the earliest next grant is WR_WAIT+1 cycles after done_o.
- The WR_HOLD counter width is $clog2(WR_WAIT+1). It clears on entry and never wraps.

## Configuration
- IIC_ARB_TIMEOUT_EN defined:
  - A counter runs in BUSY. At TIMEOUT_CYC cycles without a done edge, the block pulses done_o[winner] and err_o together, leaves rdata_o unchanged, skips WR_HOLD, and goes to IDLE.
  - A late core_done from that transaction is ignored.
- IIC_ARB_TIMEOUT_EN undefined: BUSY waits indefinitely, err_o is tied 0, and no counter is built.

## Structure
- A shared package iic_pkg holds:
  - the state enum
  - EEPROM_DEV_ADDR = 7'b1010000
  - EEPROM_ADDR_W = 13
  - default WR_WAIT and TIMEOUT_CYC constants
- One sub-module, iic_done_sync, contains the 2-FF synchroniser and the rising-edge detector, producing done_s_rise.

## Test plan
- Read: req_i=01, we=0, addr0=13'd30. Model asserts core_done after 50 cycles with rdata 8'hA5.
  - Expect gnt_o=01, a single core_re_en pulse with core_addr=30, done_o=01 three cycles after core_done, and rdata_o=8'hA5.
- Write hold: req0 write to addr 40 with data 8'h80, and req1 read raised right after done_o. Use WR_WAIT=100.
  - Expect gnt_o=10 exactly 101 cycles after done_o[0].
- Contention: req_i=11 held continuously, all reads.
  - Expect grants in the order 0,1,0,1, with no back-to-back grant to the same requester.
- Request drop: req0 deasserted in BUSY.
  - Expect done_o[0] still to pulse, with no spurious grant.
- Reset mid-BUSY: assert rst_n=0.
  - Expect all outputs 0 immediately. After release, a new request is granted normally and the stale core_done is ignored.
- Timeout (with IIC_ARB_TIMEOUT_EN, TIMEOUT_CYC=64): core_done never arrives.
  - Expect done_o and err_o together 64 cycles into BUSY, followed by IDLE.
